// File: rtl/mem_stage_pkg.sv
// Shared types and default widths for the memory stage.
package mem_stage_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefRegW  = 3;

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    // Canonical MEM/WB bundle layout at the default widths.
    typedef struct packed {
        logic                valid;
        logic                memtoreg;
        logic                regwrite;
        logic                halt;
        logic                err;
        logic [DefDataW-1:0] memout;
        logic [DefDataW-1:0] data;
        logic [DefRegW-1:0]  wreg;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: bubble clears the bundle, load captures it, otherwise hold.
module mem_wb_reg
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned REG_W  = DefRegW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  logic              d_valid,
    input  logic              d_memtoreg,
    input  logic              d_regwrite,
    input  logic              d_halt,
    input  logic              d_err,
    input  logic [DATA_W-1:0] d_memout,
    input  logic [DATA_W-1:0] d_data,
    input  logic [REG_W-1:0]  d_wreg,
    output logic              q_valid,
    output logic              q_memtoreg,
    output logic              q_regwrite,
    output logic              q_halt,
    output logic              q_err,
    output logic [DATA_W-1:0] q_memout,
    output logic [DATA_W-1:0] q_data,
    output logic [REG_W-1:0]  q_wreg
);

    // Bubble takes priority over load so a stalled cycle never retires a stale bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid    <= 1'b0;
            q_memtoreg <= 1'b0;
            q_regwrite <= 1'b0;
            q_halt     <= 1'b0;
            q_err      <= 1'b0;
            q_memout   <= '0;
            q_data     <= '0;
            q_wreg     <= '0;
        end else if (bubble) begin
            q_valid    <= 1'b0;
            q_memtoreg <= 1'b0;
            q_regwrite <= 1'b0;
            q_halt     <= 1'b0;
            q_err      <= 1'b0;
            q_memout   <= '0;
            q_data     <= '0;
            q_wreg     <= '0;
        end else if (load) begin
            q_valid    <= d_valid;
            q_memtoreg <= d_memtoreg;
            q_regwrite <= d_regwrite;
            q_halt     <= d_halt;
            q_err      <= d_err;
            q_memout   <= d_memout;
            q_data     <= d_data;
            q_wreg     <= d_wreg;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to a variable-latency data memory, stalls upstream
// while an access is outstanding, and retires misaligned/timed-out accesses as errors.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned REG_W    = DefRegW,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              ex_memtoreg,
    input  logic              ex_regwrite,
    input  logic              ex_halt,
    input  logic [REG_W-1:0]  ex_wreg,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_wr,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic              wb_memtoreg,
    output logic              wb_regwrite,
    output logic              wb_halt,
    output logic              wb_err,
    output logic [DATA_W-1:0] wb_memout,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_wreg
);

    localparam int unsigned WcntW = $clog2(MAX_WAIT + 1);

    state_e             state_q;
    logic [WcntW-1:0]   wcnt_q;

    logic               mem_op;
    logic               bad;
    logic               busy;
    logic               last_wait;
    logic               start;
    logic               retire;
    logic               err;
    logic [DATA_W-1:0]  memout;

    assign mem_op    = ex_valid & (ex_mem_rd | ex_mem_wr);
    assign bad       = mem_op & (ex_addr[0] | (ex_mem_rd & ex_mem_wr));
    assign busy      = (state_q == StBusy);
    assign last_wait = (wcnt_q == WcntW'(MAX_WAIT - 1));
    assign start     = ~busy & mem_op & ~bad;

    // Decide whether the EX/MEM bundle retires this cycle, and with what error/load data.
    // In IDLE a clean memory op only launches the request; the bundle retires from BUSY.
    always_comb begin
        retire = 1'b0;
        err    = 1'b0;
        memout = '0;
        if (busy) begin
            retire = dmem_ready | last_wait;
            // Ready beats timeout when both land in the same cycle.
            err    = ~dmem_ready;
            if (dmem_ready && ex_mem_rd) begin
                memout = dmem_rdata;
            end
        end else begin
            retire = ~start;
            err    = bad;
        end
    end

    // Gated with rst_n so the request and stall drop the moment reset asserts.
    assign stall      = rst_n & ~retire;
    assign dmem_req   = rst_n & (busy | start);
    assign dmem_wr    = dmem_req & ex_mem_wr;
    assign dmem_addr  = ex_addr;
    assign dmem_wdata = ex_wdata;

    // Access FSM and wait counter; the counter only advances while waiting in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StBusy;
                        wcnt_q  <= '0;
                    end
                end
                StBusy: begin
                    if (dmem_ready || last_wait) begin
                        state_q <= StIdle;
                        wcnt_q  <= '0;
                    end else begin
                        wcnt_q <= wcnt_q + WcntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    wcnt_q  <= '0;
                end
            endcase
        end
    end

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (retire),
        .bubble     (~retire),
        .d_valid    (ex_valid),
        .d_memtoreg (ex_memtoreg & ~(err & ~busy)),
        .d_regwrite (ex_regwrite & ~err),
        .d_halt     (ex_halt),
        .d_err      (err),
        .d_memout   (memout),
        .d_data     (ex_addr),
        .d_wreg     (ex_wreg),
        .q_valid    (wb_valid),
        .q_memtoreg (wb_memtoreg),
        .q_regwrite (wb_regwrite),
        .q_halt     (wb_halt),
        .q_err      (wb_err),
        .q_memout   (wb_memout),
        .q_data     (wb_data),
        .q_wreg     (wb_wreg)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: the driver pushes hand-computed MEM/WB bundles,
// a negedge monitor pops and compares whenever wb_valid is presented.
module tb_mem_stage;

    typedef struct packed {
        logic        valid;
        logic        mt;
        logic        rw;
        logic        halt;
        logic        err;
        logic [15:0] memout;
        logic [15:0] data;
        logic [2:0]  wreg;
    } wb_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rd;
        logic        wr;
        logic        mt;
        logic        rw;
        logic        halt;
        logic [2:0]  wreg;
        int          rdy;       // BUSY cycle that sees ready, 0 = never
        logic [15:0] rdata;
        int          stalls;
        logic        req;
        wb_t         exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_rd, ex_mem_wr, ex_memtoreg, ex_regwrite, ex_halt;
    logic [15:0] ex_addr, ex_wdata;
    logic [2:0]  ex_wreg;
    logic        stall, dmem_req, dmem_wr, dmem_ready;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_memtoreg, wb_regwrite, wb_halt, wb_err;
    logic [15:0] wb_memout, wb_data;
    logic [2:0]  wb_wreg;

    int checks = 0;
    int errors = 0;
    wb_t exp_q[$];

    always #5 clk = ~clk;

    mem_stage #(
        .DATA_W   (16),
        .REG_W    (3),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .ex_mem_rd   (ex_mem_rd),
        .ex_mem_wr   (ex_mem_wr),
        .ex_memtoreg (ex_memtoreg),
        .ex_regwrite (ex_regwrite),
        .ex_halt     (ex_halt),
        .ex_wreg     (ex_wreg),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_wr     (dmem_wr),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_memtoreg (wb_memtoreg),
        .wb_regwrite (wb_regwrite),
        .wb_halt     (wb_halt),
        .wb_err      (wb_err),
        .wb_memout   (wb_memout),
        .wb_data     (wb_data),
        .wb_wreg     (wb_wreg)
    );

    function automatic wb_t cur_wb();
        return {wb_valid, wb_memtoreg, wb_regwrite, wb_halt, wb_err, wb_memout, wb_data, wb_wreg};
    endfunction

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every presented MEM/WB result must match the oldest expected bundle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got=%0h expected=none at %0t", cur_wb(), $time);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (cur_wb() !== e) begin
                    errors++;
                    $display("FAIL wb_bundle got=%0h expected=%0h at %0t", cur_wb(), e, $time);
                end
            end
        end
    end

    function automatic wb_t mkwb(input logic v, input logic mt, input logic rw, input logic h,
                                 input logic e, input logic [15:0] mo, input logic [15:0] d,
                                 input logic [2:0] wr);
        return {v, mt, rw, h, e, mo, d, wr};
    endfunction

    function automatic vec_t mk(input logic [15:0] addr, input logic [15:0] wdata,
                                input logic rd, input logic wr, input logic mt, input logic rw,
                                input logic halt, input logic [2:0] wreg, input int rdy,
                                input logic [15:0] rdata, input int stalls, input logic req,
                                input wb_t exp);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.wr = wr; v.mt = mt; v.rw = rw;
        v.halt = halt; v.wreg = wreg; v.rdy = rdy; v.rdata = rdata; v.stalls = stalls;
        v.req = req; v.exp = exp;
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_memtoreg = 0; ex_regwrite = 0;
        ex_halt = 0; ex_addr = 0; ex_wdata = 0; ex_wreg = 0;
        dmem_ready = 0; dmem_rdata = 16'hDEAD;
    endtask

    task automatic run_op(input string name, input vec_t v);
        int  stalls;
        bit  done;
        stalls = 0;
        done   = 0;
        exp_q.push_back(v.exp);
        @(negedge clk);
        ex_valid = 1; ex_addr = v.addr; ex_wdata = v.wdata; ex_mem_rd = v.rd;
        ex_mem_wr = v.wr; ex_memtoreg = v.mt; ex_regwrite = v.rw; ex_halt = v.halt;
        ex_wreg = v.wreg;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dmem_ready = (c > 0 && c == v.rdy);
            dmem_rdata = dmem_ready ? v.rdata : 16'hDEAD;
            #1;
            chk({name, ".req"}, 48'(dmem_req), 48'(v.req));
            if (v.req) begin
                chk({name, ".wr"}, 48'(dmem_wr), 48'(v.wr));
                chk({name, ".addr"}, 48'(dmem_addr), 48'(v.addr));
                chk({name, ".wdata"}, 48'(dmem_wdata), 48'(v.wdata));
            end
            if (c > 0) chk({name, ".bubble"}, 48'(cur_wb()), 48'(0));
            if (stall) stalls++;
            else done = 1;
        end
        if (!done) begin
            errors++;
            $display("FAIL %s.stall_bound got=stuck expected=release", name);
        end
        chk({name, ".stalls"}, 48'(stalls), 48'(v.stalls));
        @(negedge clk);
        idle_inputs();
        #1;
        chk({name, ".req_after"}, 48'(dmem_req), 48'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle_inputs();
        #3;
        chk("reset.outs", {stall, dmem_req, dmem_wr, 5'(0), 40'(cur_wb())}, 48'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        run_op("alu", mk(16'h1234, 16'h0, 0, 0, 0, 1, 0, 3'd5, 0, 16'h0, 0, 0,
                         mkwb(1, 0, 1, 0, 0, 16'h0, 16'h1234, 3'd5)));
        run_op("load", mk(16'h0040, 16'h0, 1, 0, 1, 1, 0, 3'd2, 3, 16'hBEEF, 3, 1,
                          mkwb(1, 1, 1, 0, 0, 16'hBEEF, 16'h0040, 3'd2)));
        run_op("store", mk(16'h0010, 16'hA5A5, 0, 1, 0, 0, 0, 3'd0, 1, 16'h0, 1, 1,
                           mkwb(1, 0, 0, 0, 0, 16'h0, 16'h0010, 3'd0)));
        run_op("misalign", mk(16'h0003, 16'h0, 1, 0, 1, 1, 0, 3'd1, 0, 16'h0, 0, 0,
                              mkwb(1, 0, 0, 0, 1, 16'h0, 16'h0003, 3'd1)));
        run_op("rdwr", mk(16'h0004, 16'h1111, 1, 1, 1, 1, 0, 3'd3, 0, 16'h0, 0, 0,
                          mkwb(1, 0, 0, 0, 1, 16'h0, 16'h0004, 3'd3)));
        run_op("timeout", mk(16'h0008, 16'h0, 1, 0, 1, 1, 0, 3'd4, 0, 16'h0, 4, 1,
                             mkwb(1, 1, 0, 0, 1, 16'h0, 16'h0008, 3'd4)));
        run_op("ready_last", mk(16'h000A, 16'h0, 1, 0, 1, 1, 0, 3'd6, 4, 16'h1357, 4, 1,
                                mkwb(1, 1, 1, 0, 0, 16'h1357, 16'h000A, 3'd6)));
        run_op("halt", mk(16'h00FF, 16'h0, 0, 0, 0, 0, 1, 3'd7, 0, 16'h0, 0, 0,
                          mkwb(1, 0, 0, 1, 0, 16'h0, 16'h00FF, 3'd7)));

        // Abandon a load mid-BUSY with an asynchronous reset.
        @(negedge clk);
        ex_valid = 1; ex_mem_rd = 1; ex_addr = 16'h0030; ex_memtoreg = 1; ex_regwrite = 1;
        ex_wreg = 3'd2;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mid.req_before", 48'(dmem_req), 48'(1));
        chk("rst_mid.stall_before", 48'(stall), 48'(1));
        rst_n = 0;
        #1;
        chk("rst_mid.req", 48'(dmem_req), 48'(0));
        chk("rst_mid.stall", 48'(stall), 48'(0));
        chk("rst_mid.wb", 48'(cur_wb()), 48'(0));
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        #1;
        chk("rst_mid.req_release", 48'(dmem_req), 48'(0));

        run_op("after_rst", mk(16'h0020, 16'h0, 1, 0, 1, 1, 0, 3'd6, 1, 16'hCAFE, 1, 1,
                               mkwb(1, 1, 1, 0, 0, 16'hCAFE, 16'h0020, 3'd6)));

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard.drained", 48'(exp_q.size()), 48'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
